// File: rtl/uart_regs_irq.sv
// uart_regs_irq: 16550-style UART register file with IER/IIR interrupt
// priority, sticky line-status errors, character timeout, RX trigger map
// and a DIV_W-bit baud divisor.
// Optional build macro: UART_DMA_EN adds rx_dma_req_o, tx_dma_req_o and
// tx_fifo_full_i.
module uart_regs_irq #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter int DIV_W      = 16,
  parameter int TO_CHARS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [2:0]       addr_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  output logic             tx_push_o,
  output logic             rx_pop_o,
  input  logic [7:0]       rx_fifo_in,
  input  logic             rx_fifo_empty_i,
  input  logic [CNT_W-1:0] rx_fifo_count_i,
  input  logic             rx_char_i,
  input  logic [3:0]       rx_err_i,
  input  logic             tx_fifo_empty_i,
  input  logic             tsr_empty_i,
  output logic             baud_out,
  output logic             tx_rst,
  output logic             rx_rst,
  output logic [7:0]       lcr_o,
  output logic             irq_o
`ifdef UART_DMA_EN
  ,
  output logic             rx_dma_req_o,
  output logic             tx_dma_req_o,
  input  logic             tx_fifo_full_i
`endif
);

  localparam int DLM_W  = DIV_W - 8;
  localparam int TO_MAX = TO_CHARS * 12;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  typedef struct packed {
    logic [1:0] trig;
    logic       dma_mode;
    logic       ena;
  } fcr_t;

  typedef enum logic [3:0] {
    ID_NONE = 4'b0001,
    ID_THRE = 4'b0010,
    ID_RDA  = 4'b0100,
    ID_RLS  = 4'b0110,
    ID_CTI  = 4'b1100
  } iir_id_t;

  logic [7:0]       lcr, scr, mcr, dll;
  logic [DLM_W-1:0] dlm;
  logic [3:0]       ier;
  fcr_t             fcr;
  logic [3:0]       err;          // {bi,fe,pe,oe}
  logic [DIV_W-1:0] baud_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             to_flag;
  logic             thre_pending, tx_empty_q;

  logic             dlab;
  logic             wr_thr, wr_dll, wr_ier, wr_dlm, wr_fcr, wr_lcr, wr_mcr, wr_scr;
  logic             rd_lsr, rd_iir;
  logic [DIV_W-1:0] divisor;
  logic [CNT_W-1:0] thresh;
  logic [3:0]       char_time;
  logic [TO_W-1:0]  to_limit;
  logic             to_clr, rda, thre_set, thre_clr;
  iir_id_t          iir_id;
  logic [7:0]       iir, lsr, rdata;

  assign dlab   = lcr[7];
  assign lcr_o  = lcr;
  assign wr_thr = wr_i & (addr_i == 3'd0) & ~dlab;
  assign wr_dll = wr_i & (addr_i == 3'd0) &  dlab;
  assign wr_ier = wr_i & (addr_i == 3'd1) & ~dlab;
  assign wr_dlm = wr_i & (addr_i == 3'd1) &  dlab;
  assign wr_fcr = wr_i & (addr_i == 3'd2);
  assign wr_lcr = wr_i & (addr_i == 3'd3);
  assign wr_mcr = wr_i & (addr_i == 3'd4);
  assign wr_scr = wr_i & (addr_i == 3'd7);
  assign rd_iir = rd_i & (addr_i == 3'd2);
  assign rd_lsr = rd_i & (addr_i == 3'd5);

  assign tx_push_o = wr_thr;
  assign rx_pop_o  = rd_i & (addr_i == 3'd0) & ~dlab;
  assign divisor   = {dlm, dll};

  // Host-writable configuration registers and FIFO clear pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      lcr    <= '0;
      ier    <= '0;
      fcr    <= '0;
      scr    <= '0;
      mcr    <= '0;
      dll    <= '0;
      dlm    <= '0;
      tx_rst <= 1'b0;
      rx_rst <= 1'b0;
    end else begin
      if (wr_lcr) lcr <= din_i;
      if (wr_ier) ier <= din_i[3:0];
      if (wr_scr) scr <= din_i;
      if (wr_mcr) mcr <= din_i;
      if (wr_dll) dll <= din_i;
      if (wr_dlm) dlm <= din_i[DLM_W-1:0];
      if (wr_fcr) fcr <= '{trig: din_i[7:6], dma_mode: din_i[3], ena: din_i[0]};
      tx_rst <= wr_fcr & din_i[2];
      rx_rst <= wr_fcr & din_i[1];
    end
  end

  // Baud tick: one pulse every divisor cycles, restarted by any divisor write
  always_ff @(posedge clk) begin
    if (!rst || wr_dll || wr_dlm || divisor == '0) begin
      baud_cnt <= '0;
      baud_out <= 1'b0;
    end else if (baud_cnt == divisor - DIV_W'(1)) begin
      baud_cnt <= '0;
      baud_out <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + DIV_W'(1);
      baud_out <= 1'b0;
    end
  end

  // Sticky line errors; a new error in the reading cycle survives the clear
  always_ff @(posedge clk) begin
    if (!rst) err <= '0;
    else      err <= (rd_lsr ? 4'b0000 : err) | rx_err_i;
  end

  assign lsr = {|err[3:1], tx_fifo_empty_i & tsr_empty_i, tx_fifo_empty_i,
                err, ~rx_fifo_empty_i};

  // RX trigger level from FCR
  always_comb begin
    thresh = CNT_W'(1);
    if (fcr.ena) begin
      case (fcr.trig)
        2'b01:   thresh = CNT_W'(FIFO_DEPTH / 4);
        2'b10:   thresh = CNT_W'(FIFO_DEPTH / 2);
        2'b11:   thresh = CNT_W'(FIFO_DEPTH - 2);
        default: thresh = CNT_W'(1);
      endcase
    end
  end

  // start + data(5..8) + parity + stop(1..2)
  assign char_time = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + {3'b000, lcr[2]};
  assign to_limit  = TO_W'(TO_CHARS * int'(char_time));
  assign to_clr    = rx_char_i | rx_pop_o | rx_rst | rx_fifo_empty_i;

  // Character-timeout counter; stops once the flag is up
  always_ff @(posedge clk) begin
    if (!rst || to_clr) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (baud_out && !to_flag) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt + TO_W'(1) >= to_limit) to_flag <= 1'b1;
    end
  end

  assign rda = ier[0] & (rx_fifo_count_i >= thresh);

  // Interrupt source priority encoder
  always_comb begin
    iir_id = ID_NONE;
    if (ier[2] && |err)                iir_id = ID_RLS;
    else if (rda)                      iir_id = ID_RDA;
    else if (ier[0] && to_flag)        iir_id = ID_CTI;
    else if (ier[1] && thre_pending)   iir_id = ID_THRE;
  end

  assign iir = {{2{fcr.ena}}, 2'b00, iir_id};

  assign thre_set = (tx_fifo_empty_i & ~tx_empty_q) |
                    (wr_ier & din_i[1] & ~ier[1] & tx_fifo_empty_i);
  assign thre_clr = wr_thr | (rd_iir & (iir_id == ID_THRE));

  // THRE pending latch; edge detector starts high so reset is not an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      thre_pending <= 1'b0;
      tx_empty_q   <= 1'b1;
    end else begin
      thre_pending <= thre_set | (thre_pending & ~thre_clr);
      tx_empty_q   <= tx_fifo_empty_i;
    end
  end

  // Read data mux
  always_comb begin
    rdata = 8'h00;
    case (addr_i)
      3'd0:    rdata = dlab ? dll : rx_fifo_in;
      3'd1:    rdata = dlab ? 8'(dlm) : {4'b0000, ier};
      3'd2:    rdata = iir;
      3'd3:    rdata = lcr;
      3'd4:    rdata = mcr;
      3'd5:    rdata = lsr;
      3'd6:    rdata = 8'h00;
      default: rdata = scr;
    endcase
  end

  // Registered read data and interrupt line
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (rd_i) dout_o <= rdata;
      irq_o <= ~iir[0];
    end
  end

`ifdef UART_DMA_EN
  logic rx_dma_q;

  // Mode-1 RX request: raised at trigger or timeout, held until RX drains
  always_ff @(posedge clk) begin
    if (!rst)                                            rx_dma_q <= 1'b0;
    else if (rx_fifo_empty_i)                            rx_dma_q <= 1'b0;
    else if ((rx_fifo_count_i >= thresh) || to_flag)     rx_dma_q <= 1'b1;
  end

  assign rx_dma_req_o = fcr.dma_mode ? rx_dma_q : ~rx_fifo_empty_i;
  assign tx_dma_req_o = fcr.dma_mode ? ~tx_fifo_full_i : tx_fifo_empty_i;
`else
  logic unused_dma_mode;
  assign unused_dma_mode = fcr.dma_mode;
`endif

endmodule
